p1_pos_ctrl: RTL and testbench
==============================

P1_POS_CTRL -- requirements
Module: p1_pos_ctrl

Interface
REQ-001 The module SHALL have parameter Y_RESET, default 11'd215, giving the P1_y value loaded on reset (vertical centre).
REQ-002 The module SHALL have parameter STEP, default 11'd2, giving pixels moved per frame at base speed.
REQ-003 The module SHALL have port clk, input, 1, system clock; one clock only.
REQ-004 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The module SHALL have port h_cnt, input, 10, VGA horizontal pixel counter.
REQ-006 The module SHALL have port v_cnt, input, 10, VGA vertical line counter.
REQ-007 The module SHALL have port btn_up, input, 1, raw asynchronous up button, level.
REQ-008 The module SHALL have port btn_down, input, 1, raw asynchronous down button, level.
REQ-009 The module SHALL have port enable, input, 1, game-running qualifier.
REQ-010 The module SHALL have port P1_y, output, 11, registered top line of the player-1 sprite, consumed by mem_addr_gen_P1.
REQ-011 The module SHALL have port moving, output, 1, high while the FSM is in UP or DOWN.
REQ-012 The module SHALL have port frame_tick, output, 1, one-cycle pulse at the start of vertical blanking.

Function
REQ-013 btn_up and btn_down SHALL each pass through a 2-flop synchroniser before any use.
REQ-014 vblank SHALL be (v_cnt >= 480), registered; frame_tick SHALL pulse for exactly one clk on the 0->1 edge of registered vblank, independent of h_cnt pace.
REQ-015 P1_y SHALL change only on the cycle after frame_tick, so it is stable throughout every active-video frame.
REQ-016 The FSM SHALL have states IDLE, UP, DOWN, evaluated only on frame_tick, with all other cycles holding state.
REQ-017 On frame_tick: only up pressed -> UP; only down pressed -> DOWN; both or neither pressed -> IDLE; enable low -> IDLE regardless of buttons.
REQ-018 In UP: P1_y SHALL become P1_y - step when P1_y >= step, else 0 (saturate, no wrap).
REQ-019 In DOWN: P1_y SHALL become min(P1_y + step, 430), where 430 = 480 - sprite height 50.
REQ-020 In IDLE, and whenever enable is low, P1_y SHALL hold.
REQ-021 All arithmetic SHALL be 11-bit unsigned; an intermediate sum SHALL be compared before assignment so P1_y never exceeds 430.
REQ-022 moving SHALL be registered and SHALL equal (state != IDLE).

Reset
REQ-023 While rst is high, outputs SHALL be: P1_y = Y_RESET, moving = 0, frame_tick = 0; FSM = IDLE; synchronisers, vblank register and hold counter = 0.
REQ-024 Reset asserted mid-frame SHALL take effect immediately; after release, no movement SHALL occur before the first subsequent frame_tick.

Configuration
REQ-025 With macro P1_ACCEL_EN defined, a 4-bit saturating hold counter SHALL count consecutive frame_ticks in the same non-IDLE direction.
REQ-026 Under P1_ACCEL_EN, step SHALL be STEP when the counter is < 8 and 2*STEP when it is >= 8; direction change, IDLE or enable low SHALL clear the counter.
REQ-027 Without P1_ACCEL_EN, step SHALL be constant STEP and no hold counter SHALL exist.

Structure
REQ-028 A shared package p1_pkg SHALL hold SCREEN_H = 480, SPRITE_H = 50, P1_Y_MAX = 430, the FSM state typedef and the ACCEL_THRESH = 8 constant.
REQ-029 A single sub-module, vblank_tick, SHALL implement the vblank register and the edge pulse (REQ-014).

Verification
REQ-030 Reset, then release with buttons idle for 3 frames -> P1_y = 215, moving = 0, exactly 3 frame_tick pulses.
REQ-031 Hold btn_up for 5 frames from 215 -> P1_y = 205; each change lands 1 clk after frame_tick; value stable while v_cnt < 480.
REQ-032 Set P1_y = 1 and hold up -> next frame P1_y = 0, then stays 0; hold down from 429 -> 430, then stays 430.
REQ-033 Press both buttons together -> state IDLE, P1_y unchanged; drop enable while holding down -> P1_y frozen, moving = 0.
REQ-034 With P1_ACCEL_EN, hold down from 0 for 10 frames -> 8 steps of 2 then 2 steps of 4, P1_y = 24; reverse direction -> next step is 2.
REQ-035 Assert rst mid-frame while moving -> P1_y = 215 immediately; after release, no change until the next vblank edge.

Source files
------------

// File: rtl/p1_pkg.sv
// -----------------------------------------------------------------------------
// p1_pkg
// Shared constants and types for the player-1 position controller.
//   SCREEN_H     : visible lines per frame; v_cnt at or above this is vblank
//   SPRITE_H     : player-1 sprite height in lines
//   P1_Y_MAX     : lowest legal top line, so the sprite stays fully visible
//   ACCEL_THRESH : consecutive same-direction frames before the step doubles
//   p1_state_t   : movement FSM state encoding
// -----------------------------------------------------------------------------
package p1_pkg;

    localparam logic [10:0] SCREEN_H     = 11'd480;
    localparam logic [10:0] SPRITE_H     = 11'd50;
    localparam logic [10:0] P1_Y_MAX     = SCREEN_H - SPRITE_H;
    localparam logic [3:0]  ACCEL_THRESH = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } p1_state_t;

endpackage

// File: rtl/vblank_tick.sv
// -----------------------------------------------------------------------------
// vblank_tick
// Registers the vertical-blanking condition and emits a single-cycle pulse
// on its rising edge, giving one tick per frame whatever the h_cnt pace.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   v_cnt_i      : VGA vertical line counter
//   frame_tick_o : registered one-clock pulse at the start of vblank
// -----------------------------------------------------------------------------
module vblank_tick
    import p1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] v_cnt_i,
    output logic       frame_tick_o
);

    logic vblank_q, vblank_d;
    logic tick_q, tick_d;

    always_comb begin
        vblank_d = ({1'b0, v_cnt_i} >= SCREEN_H);
        // Pulse rises in the same cycle registered vblank first reads 1.
        tick_d   = vblank_d & ~vblank_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            vblank_q <= vblank_d;
            tick_q   <= tick_d;
        end
    end

    assign frame_tick_o = tick_q;

endmodule

// File: rtl/p1_pos_ctrl.sv
// -----------------------------------------------------------------------------
// p1_pos_ctrl
// Player-1 paddle vertical position controller. Buttons are synchronised,
// the movement FSM is evaluated once per frame on frame_tick, and P1_y is
// updated on the same edge so the new value appears the cycle after the
// tick and stays constant through the whole active-video frame.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   h_cnt       : VGA horizontal counter (not needed for frame pacing)
//   v_cnt       : VGA vertical counter, drives vblank detection
//   btn_up/down : raw asynchronous button levels
//   enable      : game-running qualifier; low forces IDLE and freezes P1_y
//   P1_y        : registered sprite top line, clamped to [0, P1_Y_MAX]
//   moving      : registered, high while FSM is UP or DOWN
//   frame_tick  : one-clock pulse at the start of vblank
// Build option: define P1_ACCEL_EN to double the step after ACCEL_THRESH
// consecutive frames moving in the same direction.
// -----------------------------------------------------------------------------
module p1_pos_ctrl
    import p1_pkg::*;
#(
    parameter logic [10:0] Y_RESET = 11'd215,
    parameter logic [10:0] STEP    = 11'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        enable,
    output logic [10:0] P1_y,
    output logic        moving,
    output logic        frame_tick
);

    logic unused_h;
    assign unused_h = ^h_cnt;

    logic up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
    p1_state_t   state_q, state_d;
    logic [10:0] y_q, y_d;
    logic        moving_q, moving_d;
    logic [10:0] step;
    logic [10:0] sum;
    logic        tick;

`ifdef P1_ACCEL_EN
    logic [3:0] hold_q, hold_d;
`endif

    vblank_tick u_vblank_tick (
        .clk          (clk),
        .rst          (rst),
        .v_cnt_i      (v_cnt),
        .frame_tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_s1_q <= 1'b0;
            up_s2_q <= 1'b0;
            dn_s1_q <= 1'b0;
            dn_s2_q <= 1'b0;
        end else begin
            up_s1_q <= btn_up;
            up_s2_q <= up_s1_q;
            dn_s1_q <= btn_down;
            dn_s2_q <= dn_s1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        moving_d = moving_q;
        step     = STEP;
        sum      = y_q + STEP;
`ifdef P1_ACCEL_EN
        hold_d   = hold_q;
`endif
        if (tick) begin
            if (!enable)                 state_d = ST_IDLE;
            else if (up_s2_q && !dn_s2_q) state_d = ST_UP;
            else if (dn_s2_q && !up_s2_q) state_d = ST_DOWN;
            else                          state_d = ST_IDLE;

`ifdef P1_ACCEL_EN
            // The counter holds the number of earlier consecutive frames in
            // the current direction; a fresh direction starts counting at 1.
            if (state_d == ST_IDLE) begin
                hold_d = 4'd0;
            end else if (state_d == state_q) begin
                if (hold_q >= ACCEL_THRESH) step = STEP << 1;
                if (hold_q != 4'hF)         hold_d = hold_q + 4'd1;
            end else begin
                hold_d = 4'd1;
            end
`endif

            // 11-bit sum is checked against the limit before it is stored.
            sum = y_q + step;
            case (state_d)
                ST_UP:   y_d = (y_q >= step) ? (y_q - step) : 11'd0;
                ST_DOWN: y_d = (sum > P1_Y_MAX) ? P1_Y_MAX : sum;
                default: y_d = y_q;
            endcase
            moving_d = (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            y_q      <= Y_RESET;
            moving_q <= 1'b0;
`ifdef P1_ACCEL_EN
            hold_q   <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            moving_q <= moving_d;
`ifdef P1_ACCEL_EN
            hold_q   <= hold_d;
`endif
        end
    end

    assign P1_y       = y_q;
    assign moving     = moving_q;
    assign frame_tick = tick;

endmodule

// File: tb/tb_p1_pos_ctrl.sv
module tb_p1_pos_ctrl;

    localparam int FRAME = 35;  // v_cnt steps by 15 from 0 to 510

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        btn_up, btn_down, enable;
    logic [10:0] P1_y;
    logic        moving, frame_tick;

    int n_vec = 0;
    int n_err = 0;

    int m_y, m_state, m_cnt;    // model: state 0 idle, 1 up, 2 down
    logic [11:0] exp_q[$];      // {moving, P1_y}
    logic prev_tick;
    int   ticks, pops;

    p1_pos_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .enable     (enable),
        .P1_y       (P1_y),
        .moving     (moving),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            v_cnt = (v_cnt >= 10'd510) ? 10'd0 : v_cnt + 10'd15;
            h_cnt = (h_cnt >= 10'd793) ? 10'd0 : h_cnt + 10'd7;
        end
    end

    task automatic model_reset();
        m_y = 215; m_state = 0; m_cnt = 0;
        exp_q.delete();
        prev_tick = 1'b0;
    endtask

    task automatic model_tick();
        int ns, st;
        if (!enable)                ns = 0;
        else if (btn_up && !btn_down) ns = 1;
        else if (btn_down && !btn_up) ns = 2;
        else                         ns = 0;
        st = 2;
`ifdef P1_ACCEL_EN
        if (ns == 0) m_cnt = 0;
        else if (ns == m_state) begin
            if (m_cnt >= 8) st = 4;
            if (m_cnt < 15) m_cnt++;
        end else m_cnt = 1;
`endif
        if (ns == 1) m_y = (m_y >= st) ? m_y - st : 0;
        else if (ns == 2) m_y = (m_y + st > 430) ? 430 : m_y + st;
        m_state = ns;
        exp_q.push_back({(ns != 0), m_y[10:0]});
    endtask

    task automatic cycle();
        logic [11:0] e;
        @(posedge clk); #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            n_vec++;
            if (P1_y !== e[10:0]) begin
                n_err++;
                $display("FAIL frame_update P1_y=%0d expected %0d", P1_y, e[10:0]);
            end
            n_vec++;
            if (moving !== e[11]) begin
                n_err++;
                $display("FAIL frame_moving moving=%b expected %b", moving, e[11]);
            end
        end else begin
            n_vec++;
            if (P1_y !== m_y[10:0]) begin
                n_err++;
                $display("FAIL hold_in_frame P1_y=%0d expected %0d (v_cnt=%0d)", P1_y, m_y, v_cnt);
            end
        end
        if (frame_tick === 1'b1) begin
            n_vec++;
            if (prev_tick !== 1'b0) begin
                n_err++;
                $display("FAIL tick_width frame_tick high two cycles, expected one");
            end
            ticks++;
            model_tick();
        end
        prev_tick = frame_tick;
    endtask

    task automatic run_frames(input int n);
        int target, k;
        target = pops + n;
        k = 0;
        while (pops < target && k < (n + 2) * FRAME) begin
            cycle();
            k++;
        end
        n_vec++;
        if (pops < target) begin
            n_err++;
            $display("FAIL frame_timeout got %0d updates expected %0d", pops - (target - n), n);
        end
    endtask

    // Assert reset in the middle of active video and check its immediate effect.
    task automatic reset_midframe();
        int k;
        k = 0;
        while (v_cnt != 10'd240 && k < 2 * FRAME) begin
            cycle();
            k++;
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (P1_y !== 11'd215) begin
            n_err++;
            $display("FAIL midreset_y P1_y=%0d expected 215", P1_y);
        end
        n_vec++;
        if (moving !== 1'b0 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_ctl moving=%b tick=%b expected 0 0", moving, frame_tick);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int t0;
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (P1_y !== 11'd215 || moving !== 1'b0 || frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state y=%0d moving=%b tick=%b expected 215 0 0", P1_y, moving, frame_tick);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        t0 = ticks;
        repeat (3 * FRAME) cycle();
        n_vec++;
        if (ticks - t0 !== 3) begin
            n_err++;
            $display("FAIL idle_tick_count got %0d expected 3", ticks - t0);
        end
        run_frames(0);
        n_vec++;
        if (P1_y !== 11'd215 || moving !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold y=%0d moving=%b expected 215 0", P1_y, moving);
        end
    endtask

    task automatic test_up5();
        run_frames(1);   // realign to just after a frame update
        btn_up = 1'b1;
        run_frames(5);
        n_vec++;
        if (P1_y !== 11'd205 || moving !== 1'b1) begin
            n_err++;
            $display("FAIL up5 y=%0d moving=%b expected 205 1", P1_y, moving);
        end
    endtask

    task automatic test_down_sat();
        int k;
        btn_up = 1'b0; btn_down = 1'b1;
        k = 0;
        while (m_y != 429 && k < 200) begin
            run_frames(1);
            k++;
        end
        n_vec++;
        if (P1_y !== 11'd429) begin
            n_err++;
            $display("FAIL reach_429 y=%0d expected 429", P1_y);
        end
        for (int i = 0; i < 2; i++) begin
            run_frames(1);
            n_vec++;
            if (P1_y !== 11'd430) begin
                n_err++;
                $display("FAIL bottom_clamp y=%0d expected 430", P1_y);
            end
        end
    endtask

    task automatic test_up_sat();
        int k;
        btn_down = 1'b0;
        reset_midframe();
        btn_up = 1'b1;
        k = 0;
        while (m_y != 0 && k < 200) begin
            run_frames(1);
            k++;
        end
        for (int i = 0; i < 2; i++) begin
            run_frames(1);
            n_vec++;
            if (P1_y !== 11'd0) begin
                n_err++;
                $display("FAIL top_clamp y=%0d expected 0", P1_y);
            end
        end
    endtask

    task automatic test_both_enable();
        logic [10:0] rec;
        btn_up = 1'b0; btn_down = 1'b1;
        run_frames(3);
        rec = P1_y;
        btn_up = 1'b1;
        run_frames(2);
        n_vec++;
        if (P1_y !== rec || moving !== 1'b0) begin
            n_err++;
            $display("FAIL both_pressed y=%0d moving=%b expected %0d 0", P1_y, moving, rec);
        end
        btn_up = 1'b0;
        run_frames(2);
        rec = P1_y;
        enable = 1'b0;
        run_frames(2);
        n_vec++;
        if (P1_y !== rec || moving !== 1'b0) begin
            n_err++;
            $display("FAIL enable_low y=%0d moving=%b expected %0d 0", P1_y, moving, rec);
        end
        enable = 1'b1;
    endtask

    task automatic test_accel();
        int k;
        btn_down = 1'b0;
        btn_up = 1'b1;
        k = 0;
        while (m_y != 0 && k < 200) begin
            run_frames(1);
            k++;
        end
        btn_up = 1'b0;
        run_frames(1);   // IDLE frame clears any direction history
        btn_down = 1'b1;
        run_frames(10);
        n_vec++;
`ifdef P1_ACCEL_EN
        if (P1_y !== 11'd24) begin
            n_err++;
            $display("FAIL accel_10 y=%0d expected 24", P1_y);
        end
`else
        if (P1_y !== 11'd20) begin
            n_err++;
            $display("FAIL const_step_10 y=%0d expected 20", P1_y);
        end
`endif
        btn_down = 1'b0; btn_up = 1'b1;
        run_frames(1);
        n_vec++;
`ifdef P1_ACCEL_EN
        if (P1_y !== 11'd22) begin
            n_err++;
            $display("FAIL reverse_step y=%0d expected 22", P1_y);
        end
`else
        if (P1_y !== 11'd18) begin
            n_err++;
            $display("FAIL reverse_step y=%0d expected 18", P1_y);
        end
`endif
    endtask

    task automatic test_midframe_reset();
        btn_up = 1'b0; btn_down = 1'b1;
        run_frames(2);
        n_vec++;
        if (moving !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_moving moving=%b expected 1", moving);
        end
        reset_midframe();
        run_frames(1);
        n_vec++;
        if (P1_y !== 11'd217) begin
            n_err++;
            $display("FAIL post_reset_step y=%0d expected 217", P1_y);
        end
    endtask

    initial begin
        rst = 1'b1;
        v_cnt = 10'd0; h_cnt = 10'd0;
        btn_up = 1'b0; btn_down = 1'b0; enable = 1'b1;
        ticks = 0; pops = 0;
        model_reset();
        test_reset();
        test_up5();
        test_down_sat();
        test_up_sat();
        test_both_enable();
        test_accel();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
